// File: rtl/result_mux_shift.sv
// Write-back result selector: passes one of NCH ALU channels through, or
// shifts/rotates channel 0 one bit per cycle, with a registered Start/Busy/Valid handshake.
module result_mux_shift #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [2:0]           i_op,
  input  logic [NCH*WIDTH-1:0] i_hyrja,
  input  logic [SHW-1:0]       i_shamt,
  output logic [WIDTH-1:0]     o_dalja,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic [SHW-1:0]   r_cnt;
  logic [SHW-1:0]   w_cnt_nxt;
  logic [1:0]       r_kind;
  logic [1:0]       w_kind_nxt;
  logic [WIDTH-1:0] r_dalja;
  logic [WIDTH-1:0] w_dalja_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  logic [WIDTH-1:0] w_ch0;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_step;

  // One-bit shift of the work register according to the latched op
  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] kind,
                                                 input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    res = v;
    case (kind)
      OP_SRL:  res = {1'b0, v[WIDTH-1:1]};
      OP_ROR:  res = {v[0], v[WIDTH-1:1]};
      OP_SLL:  res = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  res = {v[WIDTH-1], v[WIDTH-1:1]};
      default: res = v;
    endcase
    return res;
  endfunction

  assign w_ch0  = i_hyrja[WIDTH-1:0];
  assign w_step = shift_one(r_kind, r_work);

  // Channel index beyond NCH falls through to channel 0
  always_comb begin
    w_sel = w_ch0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (i_op[1:0] == 2'(i)) begin
        w_sel = i_hyrja[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_kind  <= OP_SRL;
      r_dalja <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_kind  <= w_kind_nxt;
      r_dalja <= w_dalja_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_kind_nxt  = r_kind;
    w_dalja_nxt = r_dalja;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (!i_op[2]) begin
            w_dalja_nxt = w_sel;
            w_valid_nxt = 1'b1;
          end else if (i_shamt == '0) begin
            w_dalja_nxt = w_ch0;
            w_valid_nxt = 1'b1;
          end else begin
            w_work_nxt  = w_ch0;
            w_cnt_nxt   = i_shamt;
            w_kind_nxt  = i_op[1:0];
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        // Start is ignored here; operands were captured on entry
        w_work_nxt = w_step;
        w_cnt_nxt  = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_dalja_nxt = w_step;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_dalja = r_dalja;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_result_mux_shift.sv
// Directed bench for result_mux_shift: scoreboard of expected result/latency,
// checked with immediate assertions when Valid appears.
module tb_result_mux_shift;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [63:0] hyrja = '0;
  logic [3:0]  shamt = '0;
  logic [15:0] dalja, dalja3;
  logic        valid, busy, valid3, busy3;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  result_mux_shift #(.WIDTH(16), .NCH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op), .i_hyrja(hyrja),
    .i_shamt(shamt), .o_dalja(dalja), .o_valid(valid), .o_busy(busy)
  );

  result_mux_shift #(.WIDTH(16), .NCH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op), .i_hyrja(hyrja[47:0]),
    .i_shamt(shamt), .o_dalja(dalja3), .o_valid(valid3), .o_busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; Start is sampled on the next rising edge
  task automatic issue(input logic [2:0] o, input logic [3:0] s,
                       input logic [15:0] e, input int lat);
    exp_t x;
    op = o;
    shamt = s;
    start = 1'b1;
    x.data = e;
    x.lat = lat;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = rising edges already elapsed since Start was sampled
  task automatic collect(input string tag, input int n0, input bit chk_drop);
    exp_t x;
    int n;
    int bcnt;
    n = n0;
    bcnt = (n0 > 1) ? n0 - 1 : 0;
    while (!valid && n < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_data"}, 32'(dalja), 32'(x.data));
      chk({tag, "_lat"}, 32'(n), 32'(x.lat));
      chk({tag, "_busycyc"}, 32'(bcnt), 32'(x.lat - 1));
    end
    chk({tag, "_busy_at_valid"}, 32'(busy), 32'd0);
    if (chk_drop) begin
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(valid), 32'd0);
    end
  endtask

  initial begin
    bit saw_valid;
    // Power-on reset
    #2;
    chk("rst0_dalja", 32'(dalja), 32'h0);
    chk("rst0_valid", 32'(valid), 32'h0);
    chk("rst0_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pass channel 2
    hyrja = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
    issue(3'b010, 4'd0, 16'h1234, 1);
    collect("pass_ch2", 1, 1'b1);

    // Async reset between edges clears outputs at once
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dalja", 32'(dalja), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_hold_dalja", 32'(dalja), 32'h0);
    chk("arst_hold_valid", 32'(valid), 32'h0);

    // Op=011: channel 3 on NCH=4, falls back to channel 0 on NCH=3
    hyrja = {16'h3333, 16'h2222, 16'hBBBB, 16'h1111};
    issue(3'b011, 4'd0, 16'h3333, 1);
    chk("nch3_valid", 32'(valid3), 32'd1);
    chk("nch3_dalja", 32'(dalja3), 32'h1111);
    collect("pass_ch3", 1, 1'b1);

    // SLL by 4, then SLL by 0
    hyrja = {48'h0, 16'h0001};
    issue(3'b110, 4'd4, 16'h0010, 5);
    collect("sll4", 1, 1'b1);
    issue(3'b110, 4'd0, 16'h0001, 1);
    collect("sll0", 1, 1'b1);

    // ROR by 1, then back-to-back pass, SRA 15, SRL 15 each issued in the Valid cycle
    issue(3'b101, 4'd1, 16'h8000, 2);
    collect("ror1", 1, 1'b0);
    hyrja = {32'h0, 16'hBEEF, 16'h8000};
    issue(3'b001, 4'd0, 16'hBEEF, 1);
    collect("b2b_pass", 1, 1'b0);
    issue(3'b111, 4'd15, 16'hFFFF, 16);
    collect("b2b_sra15", 1, 1'b0);
    issue(3'b100, 4'd15, 16'h0001, 16);
    collect("b2b_srl15", 1, 1'b1);

    // Start while busy is ignored; operand changes do not disturb the shift
    hyrja = {48'h0, 16'hF000};
    issue(3'b100, 4'd6, 16'h03C0, 7);
    chk("ign_busy", 32'(busy), 32'd1);
    hyrja = {16'h0, 16'hAAAA, 16'h0, 16'hFFFF};
    op = 3'b010;
    shamt = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_dalja_held", 32'(dalja), 32'h0001);
    chk("ign_still_busy", 32'(busy), 32'd1);
    collect("ign_srl6", 2, 1'b1);

    // Reset after 3 shift edges of SLL 8 aborts without Valid
    hyrja = {48'h0, 16'h0001};
    issue(3'b110, 4'd8, 16'h0100, 9);
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dalja", 32'(dalja), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid || busy) saw_valid = 1'b1;
    end
    chk("mid_no_valid", 32'(saw_valid), 32'd0);
    hyrja = {48'h0, 16'h0005};
    issue(3'b110, 4'd8, 16'h0500, 9);
    collect("post_rst_sll8", 1, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/result_mux_shift.md
Name: result_mux_shift

Overview:
- Parametrised, sequential successor to the CPU's ALU result selector.
- Selects one of NCH ALU result channels, or produces a shift/rotate of channel 0 using an iterative one-bit-per-cycle shifter.
- Output is registered, with Start/Busy/Valid handshake; sits between the ALU functional units and the register-file write-back.

Parameters:
- WIDTH, 16, datapath width; power of two, >= 4.
- NCH, 4, number of pass-through result channels; 1..4.
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Op     input  3  operation code, captured with Start.
- Hyrja  input  NCH*WIDTH  flattened result channels; channel i = Hyrja[i*WIDTH +: WIDTH].
- Shamt  input  SHW  shift amount, captured with Start.
- Dalja  output WIDTH  registered result; holds last result until the next Valid.
- Valid  output 1  one-cycle pulse; Dalja is updated on the same edge.
- Busy   output 1  high while an iterative shift is in progress.

Behaviour:
- Reset (Reset=0, asynchronous): Dalja=0, Valid=0, Busy=0, FSM=IDLE, work register=0, counter=0. Reset mid-operation aborts the operation with no Valid.
- Op encoding:
  - 000..011: pass channel Op[1:0]; index >= NCH selects channel 0.
  - 100 SRL, 101 ROR, 110 SLL, 111 SRA; all shift/rotate ops use channel 0 as source.
- FSM states: IDLE, SHIFT.
- IDLE, Start=1, pass op, or shift op with Shamt=0:
  - Next edge: Dalja = selected channel (or unshifted channel 0), Valid=1; stay IDLE.
  - Latency 1; Busy never asserts.
- IDLE, Start=1, shift op with Shamt=k>0:
  - Next edge: work = channel 0, counter = k, op latched, Busy=1, go SHIFT.
- SHIFT, each edge: work shifts one bit per latched op; counter decrements.
  - SLL: zero-fill at LSB.
  - SRL: zero-fill at MSB.
  - SRA: MSB replicated.
  - ROR: LSB moves to MSB.
- SHIFT, on the edge where counter goes 1 -> 0: Dalja = shifted value, Valid=1, Busy=0, go IDLE. Total latency k+1 edges after Start is sampled.
- Start while Busy=1: ignored, no effect, no error indication.
- Start in the cycle Valid=1: FSM is already IDLE, so it is accepted (back-to-back issue).
- Hyrja and Shamt changes after capture do not affect an in-flight shift.
- Valid is never high for more than one consecutive cycle unless Start is re-issued on pass ops every cycle; in that case Valid stays high continuously.
- Dalja is never X after reset, and changes only on Valid edges or reset.
- Widths: no internal width growth; results are truncated to WIDTH.

Test Plan (WIDTH=16, NCH=4):
1. Reset asserted asynchronously between edges -> Dalja=0x0000, Valid=0, Busy=0 immediately; values held through release.
2. Pass: Hyrja ch2=0x1234, Op=010, Start for 1 cycle -> next edge Valid=1, Dalja=0x1234, Busy stays 0. Repeat with NCH=3 and Op=011 -> Dalja = ch0.
3. SLL: ch0=0x0001, Shamt=4, Op=110 -> Busy high for 4 cycles, Valid on edge 5, Dalja=0x0010. Shamt=0 -> Dalja=0x0001 at edge 1.
4. SRA vs SRL: ch0=0x8000, Shamt=15 -> Op=111 gives 0xFFFF; Op=100 gives 0x0001. Each produces Valid on edge 16.
5. ROR and handshake:
   - ch0=0x0001, Shamt=1, Op=101 -> Dalja=0x8000.
   - Start pulsed with ch2 while Busy -> ignored; Dalja unchanged until the correct result.
   - New Start in the Valid cycle -> accepted; second result appears at its expected latency.
6. Reset mid-shift (SLL, Shamt=8, after 3 shift edges) -> outputs zero, no Valid. Fresh Start after release completes normally with the correct value.
